// File: rtl/scpu_fetch_pc.sv
`default_nettype none
// ============================================================================
// Module   : scpu_fetch_pc
// Purpose  : Instruction-fetch and PC-sequencing stage of the single-cycle
//            MIPS CPU. Fetches over a ready-handshaked instruction bus,
//            holds the instruction for the decoder, selects the next PC from
//            the decoder Branch/Jal outputs, stalls on outstanding data
//            accesses and handles one level of interrupt with EPC / eret.
// Revision : 1.0 - initial release
// ============================================================================
module scpu_fetch_pc #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] INT_VECTOR = 32'h0000_0004
) (
  input  logic        clk,
  input  logic        rst,
  // instruction bus
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  // decoder-facing
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic        commit,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic [1:0]  branch,
  input  logic        jal,
  input  logic [31:0] rs_data,
  // data-memory handshake
  input  logic        data_req,
  input  logic        data_ready,
  // interrupt
  input  logic        int_req,
  output logic        int_ack,
  output logic [31:0] epc
);

  // --------------------------------------------------------------------------
  // Encodings
  // --------------------------------------------------------------------------
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_EXEC  = 2'd2;

  localparam logic [1:0] BR_SEQ  = 2'b00;
  localparam logic [1:0] BR_COND = 2'b01;
  localparam logic [1:0] BR_JUMP = 2'b10;
  localparam logic [1:0] BR_REG  = 2'b11;

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_inst;
  logic [31:0] r_epc;
  logic        r_int_en;

  logic        w_in_fetch;
  logic        w_in_exec;
  logic        w_fetch_done;
  logic        w_is_eret;
  logic        w_commit;
  logic        w_take_int;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_br_offset;
  logic [31:0] w_next_pc;

  // jr targets are word aligned, so the two low register bits are dropped.
  logic        w_rs_low_unused;
  assign w_rs_low_unused = ^rs_data[1:0];

  // --------------------------------------------------------------------------
  // Status decode. Reset masks every strobe so that nothing leaks out of a
  // cycle in which rst is high, even before the state register is cleared.
  // --------------------------------------------------------------------------
  assign w_in_fetch   = (r_state == S_FETCH) && !rst;
  assign w_in_exec    = (r_state == S_EXEC)  && !rst;
  assign w_fetch_done = w_in_fetch && imem_ready;
  assign w_is_eret    = (branch == BR_REG) && !jal;
  assign w_commit     = w_in_exec && (!data_req || data_ready);
  // eret has priority: a request seen during its commit waits for the next one.
  assign w_take_int   = w_commit && int_req && r_int_en && !w_is_eret;

  // --------------------------------------------------------------------------
  // Next-PC arithmetic (32-bit, wraps silently)
  // --------------------------------------------------------------------------
  assign w_pc_plus4  = r_pc + 32'd4;
  assign w_br_offset = {{14{r_inst[15]}}, r_inst[15:0], 2'b00};

  // Select the successor PC from the decoder branch code.
  always_comb begin
    w_next_pc = w_pc_plus4;
    case (branch)
      BR_SEQ:  w_next_pc = w_pc_plus4;
      BR_COND: w_next_pc = w_pc_plus4 + w_br_offset;
      BR_JUMP: w_next_pc = {w_pc_plus4[31:28], r_inst[25:0], 2'b00};
      BR_REG:  w_next_pc = jal ? {rs_data[31:2], 2'b00} : r_epc;
      default: w_next_pc = w_pc_plus4;
    endcase
  end

  // --------------------------------------------------------------------------
  // Sequencer
  // --------------------------------------------------------------------------
  // Next-state logic: IDLE is a one-cycle post-reset hop into FETCH.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  w_state_nxt = S_FETCH;
      S_FETCH: w_state_nxt = imem_ready ? S_EXEC : S_FETCH;
      S_EXEC:  w_state_nxt = w_commit ? S_FETCH : S_EXEC;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Instruction register: captured on the cycle the fetch completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_inst <= 32'd0;
    end else if (w_fetch_done) begin
      r_inst <= imem_rdata;
    end
  end

  // PC, EPC and interrupt enable all move together on the commit edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc     <= RESET_PC;
      r_epc    <= 32'd0;
      r_int_en <= 1'b1;
    end else if (w_commit) begin
      if (w_take_int) begin
        r_epc    <= w_next_pc;
        r_pc     <= INT_VECTOR;
        r_int_en <= 1'b0;
      end else begin
        r_pc <= w_next_pc;
        if (w_is_eret) begin
          r_int_en <= 1'b1;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign imem_req   = w_in_fetch;
  assign imem_addr  = r_pc;
  assign inst       = r_inst;
  assign inst_valid = w_in_exec;
  assign commit     = w_commit;
  assign pc         = r_pc;
  assign pc_plus4   = w_pc_plus4;
  assign int_ack    = w_take_int;
  assign epc        = r_epc;

endmodule
`default_nettype wire

// File: doc/scpu_fetch_pc.md
# scpu_fetch_pc

Instruction-fetch and PC-sequencing stage of the single-cycle MIPS CPU. It sits directly upstream of the main decoder: it fetches each instruction over a ready-handshaked instruction bus and presents it to the decoder. It then consumes the decoder's `Branch`/`Jal` outputs to select the next PC, stalls while a data-memory access is outstanding, and handles one level of external interrupt with EPC save and `eret` return.

## Interface

Parameters
- `RESET_PC`, 32'h0000_0000: PC value after reset.
- `INT_VECTOR`, 32'h0000_0004: PC loaded when an interrupt is taken.

Ports
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `imem_req`  out  1  instruction fetch request.
- `imem_addr`  out  32  fetch address (equals `pc`).
- `imem_rdata`  in  32  instruction word, valid when `imem_ready`=1.
- `imem_ready`  in  1  fetch completes this cycle.
- `inst`  out  32  latched instruction register, driven to the decoder.
- `inst_valid`  out  1  `inst` is being executed this cycle.
- `commit`  out  1  instruction retires this cycle; gates register-file and memory writes.
- `pc`  out  32  PC of the current instruction.
- `pc_plus4`  out  32  `pc`+4, used for `jal` write-back.
- `branch`  in  2  decoder Branch code: 00 sequential, 01 conditional taken, 10 jump, 11 register target.
- `jal`  in  1  decoder Jal; with `branch`=11, 1 selects `jr` and 0 selects `eret`.
- `rs_data`  in  32  register rs value for `jr`.
- `data_req`  in  1  current instruction accesses data memory (load or store).
- `data_ready`  in  1  data memory completes the access (MIO_ready).
- `int_req`  in  1  level interrupt request.
- `int_ack`  out  1  one-cycle pulse when an interrupt is taken.
- `epc`  out  32  saved exception PC.

## Operation

- States: IDLE, FETCH, EXEC.
  - IDLE → FETCH unconditionally. IDLE is entered only from reset.
  - FETCH: `imem_req`=1 and `imem_addr`=`pc`. When `imem_ready`=1, `inst` <= `imem_rdata` and the state moves to EXEC. Otherwise it stays in FETCH with the address held stable.
  - EXEC: `inst_valid`=1. `commit` = !`data_req` | `data_ready`. When `commit`=1, the PC updates and the state moves to FETCH. Otherwise it stays in EXEC: `inst` and `pc` are held and `commit`=0.
- Next PC, computed in 32-bit modular arithmetic with wrap-around and no trap:
  - 00 → `pc`+4.
  - 01 → `pc`+4 + (sign-extend(`inst[15:0]`) << 2).
  - 10 → {`pc_plus4[31:28]`, `inst[25:0]`, 2'b00}.
  - 11 with `jal`=1 → {`rs_data[31:2]`, 2'b00}; the low bits are forced to 0.
  - 11 with `jal`=0 → `epc`, and `int_en` <= 1.
- Interrupt handling:
  - Internal flag `int_en` resets to 1.
  - An interrupt is taken on a commit cycle when `int_req` & `int_en` and the instruction is not `eret`.
  - When taken: `epc` <= computed next PC, `pc` <= `INT_VECTOR`, `int_en` <= 0, and `int_ack`=1 for that cycle only. The current instruction still commits.
  - If `int_req` is asserted during the `eret` commit, `eret` wins. The interrupt is taken at the next commit.
  - `int_req` is ignored while `int_en`=0.
- Reset values:
  - State IDLE.
  - `pc`=`RESET_PC`, `inst`=0, `epc`=0, `int_en`=1.
  - `imem_req`, `inst_valid`, `commit`, `int_ack` all 0.
- Reset mid-operation, in any state including a pending fetch or a stalled EXEC: all registers take their reset values at that edge, and the in-flight instruction never commits. Any `imem_ready` or `data_ready` arriving during reset is ignored.

## Timing

- `imem_req`, `inst_valid` and `imem_addr` are Moore outputs. `commit` and `int_ack` are combinational from `data_req`, `data_ready` and `int_req` in EXEC.
- Throughput is 2 cycles per instruction with zero-wait memories: 1 FETCH cycle and 1 EXEC cycle.
  - Each instruction-bus wait cycle adds 1 cycle.
  - Each cycle of `data_ready`=0 with `data_req`=1 adds 1 cycle.
- The first fetch request occurs in the second cycle after `rst` deasserts.
- `pc` and `epc` update on the commit-cycle edge. The new `imem_addr` is visible in the following FETCH cycle.
- Decoder outputs (`branch`, `jal`, `data_req`) are sampled only in EXEC. Their values in other states are don't-care.

## Test plan

1. Sequential fetch, zero-wait:
   - Stimulus: reset, then `imem_ready`=1 with all-NOP instructions.
   - Required: `imem_addr` = 0, 4, 8, 0xC on alternate cycles; `commit` pulses every 2 cycles; all outputs are 0 during reset.
2. Branch taken:
   - Stimulus: `pc`=0x10, `inst[15:0]`=0xFFFC, `branch`=01.
   - Required: next `pc`=0x04.
3. Jump-and-link:
   - Stimulus: `pc`=0x0040_0020, `inst[25:0]`=0x100, `branch`=10, `jal`=1.
   - Required: `pc_plus4`=0x0040_0024; next `pc`=0x0000_0400.
4. Register jump and fetch wait:
   - Stimulus: `branch`=11, `jal`=1, `rs_data`=0x203, with `imem_ready` held low 2 cycles on the next fetch.
   - Required: next `pc`=0x200; `imem_addr` stays 0x200 for 3 FETCH cycles.
5. Data stall:
   - Stimulus: `data_req`=1 with `data_ready`=0 for 3 cycles, then 1.
   - Required: `commit`=0 for 3 cycles with `inst_valid`=1 and `pc` unchanged, then one `commit` pulse and the PC advances.
6. Interrupt and return, plus reset mid-operation:
   - Stimulus: `int_req`=1 at the commit of a sequential instruction at 0x20.
   - Required: `int_ack` is a 1-cycle pulse; `epc`=0x24; `pc`=0x04; a second `int_req` is ignored; a later `eret` gives `pc`=0x24 and re-enables interrupts.
   - Stimulus: `rst` asserted during a stalled EXEC.
   - Required: no `commit`; `pc`=0 at the next edge.
